// File: rtl/spi_slave.sv
// Memory-mapped SPI responder: synchronises SCLK/SS_n/MOSI into clk, shifts 8-bit frames MSB-first
// in all four CPOL/CPHA modes. Define SPI_SLV_IRQ_EN to add the rx/error interrupt output.
`timescale 1ns/1ps
module spi_slave #(
  parameter logic [7:0] SPI_SLV_CTRL   = 8'h30,
  parameter logic [7:0] SPI_SLV_TXDATA = 8'h34,
  parameter logic [7:0] SPI_SLV_RXDATA = 8'h38,
  parameter logic [7:0] SPI_SLV_STATUS = 8'h3C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        req_valid_i,
  output logic [31:0] data_o,
  input  logic        spi_sclk,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
`ifdef SPI_SLV_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  state_t state_reg, state_next;

  logic [2:0]  sclk_sync, ss_sync;
  logic [1:0]  mosi_sync;
  logic        en_reg, cpol_reg, cpha_reg;
  logic [7:0]  dummy_reg, txdata_reg, rxdata_reg, tx_shift_reg;
  logic [6:0]  rx_shift_reg;
  logic [2:0]  bit_cnt_reg;
  logic        tx_empty_reg, rx_valid_reg, overrun_reg, underrun_reg, abort_reg;
  logic        busy, enter, leave;
  logic [31:0] ctrl_word, status_word, rd_mux;
  logic        unused_bits;

`ifdef SPI_SLV_IRQ_EN
  logic rx_ie_reg, err_ie_reg;
  assign ctrl_word = {14'h0, err_ie_reg, rx_ie_reg, dummy_reg, 5'h0, cpha_reg, cpol_reg, en_reg};
`else
  assign ctrl_word = {16'h0, dummy_reg, 5'h0, cpha_reg, cpol_reg, en_reg};
`endif
  assign status_word = {26'h0, abort_reg, underrun_reg, overrun_reg, busy, tx_empty_reg, rx_valid_reg};
  assign unused_bits = ^{data_i, addr_i, sel_i};

  // [1] is the synchronised level, [2] the previous level for edge detection
  wire sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  wire sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  wire ss_fall   = ~ss_sync[1] & ss_sync[2];
  wire ss_rise   = ss_sync[1] & ~ss_sync[2];

  wire wen = we_i & req_valid_i;
  wire ren = ~we_i & req_valid_i;
  wire wr_ctrl   = wen && addr_i[7:0] == SPI_SLV_CTRL;
  wire wr_tx     = wen && addr_i[7:0] == SPI_SLV_TXDATA;
  wire wr_status = wen && addr_i[7:0] == SPI_SLV_STATUS;
  wire rd_rx     = ren && addr_i[7:0] == SPI_SLV_RXDATA;

  wire active_edge = busy & ~leave;
  wire lead      = active_edge & (cpol_reg ? sclk_fall : sclk_rise);
  wire trail     = active_edge & (cpol_reg ? sclk_rise : sclk_fall);
  wire sample    = cpha_reg ? trail : lead;
  wire shift_out = cpha_reg ? lead : trail;
  wire byte_done = sample && bit_cnt_reg == 3'd7;
  wire start     = enter | byte_done;
  wire [7:0] rx_byte    = {rx_shift_reg, mosi_sync[1]};
  wire [7:0] start_byte = tx_empty_reg ? dummy_reg : txdata_reg;

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en_reg && ss_fall) state_next = ACTIVE;
      ACTIVE:  if (ss_rise || !en_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_reg == ACTIVE);
    enter = (state_reg == IDLE) && (state_next == ACTIVE);
    leave = (state_reg == ACTIVE) && (state_next == IDLE);
  end

  assign spi_miso_oe = busy;

  always_comb begin
    rd_mux = 32'h0;
    case (addr_i[7:0])
      SPI_SLV_CTRL:   rd_mux = ctrl_word;
      SPI_SLV_RXDATA: rd_mux = {24'h0, rxdata_reg};
      SPI_SLV_STATUS: rd_mux = status_word;
      default:        rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync <= 3'b000;
      ss_sync <= 3'b111;
      mosi_sync <= 2'b00;
      data_o <= 32'h0;
      en_reg <= 1'b0;
      cpol_reg <= 1'b0;
      cpha_reg <= 1'b0;
      dummy_reg <= 8'h0;
      txdata_reg <= 8'h0;
      rxdata_reg <= 8'h0;
      tx_shift_reg <= 8'h0;
      rx_shift_reg <= 7'h0;
      bit_cnt_reg <= 3'd0;
      tx_empty_reg <= 1'b1;
      rx_valid_reg <= 1'b0;
      overrun_reg <= 1'b0;
      underrun_reg <= 1'b0;
      abort_reg <= 1'b0;
      spi_miso <= 1'b0;
`ifdef SPI_SLV_IRQ_EN
      rx_ie_reg <= 1'b0;
      err_ie_reg <= 1'b0;
`endif
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_sclk};
      ss_sync <= {ss_sync[1:0], spi_ss_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      data_o <= ren ? rd_mux : 32'h0;

      if (wr_ctrl) begin
        if (sel_i[0]) begin
          en_reg <= data_i[0];
          if (!busy && !enter) begin
            cpol_reg <= data_i[1];
            cpha_reg <= data_i[2];
          end
        end
        if (sel_i[1]) dummy_reg <= data_i[15:8];
`ifdef SPI_SLV_IRQ_EN
        if (sel_i[2]) begin
          rx_ie_reg <= data_i[16];
          err_ie_reg <= data_i[17];
        end
`endif
      end

      // Flag clears come first so a same-cycle hardware set wins
      if (wr_status && sel_i[0]) begin
        if (data_i[3]) overrun_reg <= 1'b0;
        if (data_i[4]) underrun_reg <= 1'b0;
        if (data_i[5]) abort_reg <= 1'b0;
      end

      if (sample) begin
        rx_shift_reg <= rx_byte[6:0];
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
      // CPHA=0 trailing edge after the 8th sample belongs to the next byte whose MSB is already out
      if (shift_out && (cpha_reg || bit_cnt_reg != 3'd0)) begin
        spi_miso <= tx_shift_reg[7];
        tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
      end

      if (start) begin
        tx_empty_reg <= 1'b1;
        if (tx_empty_reg) underrun_reg <= 1'b1;
        if (cpha_reg) begin
          tx_shift_reg <= start_byte;
        end else begin
          tx_shift_reg <= {start_byte[6:0], 1'b0};
          spi_miso <= start_byte[7];
        end
      end

      if (byte_done) begin
        if (!rx_valid_reg || rd_rx) begin
          rxdata_reg <= rx_byte;
          rx_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (rd_rx) begin
        rx_valid_reg <= 1'b0;
      end

      if (leave) begin
        bit_cnt_reg <= 3'd0;
        spi_miso <= 1'b0;
        if (bit_cnt_reg != 3'd0) abort_reg <= 1'b1;
      end

      // A CPU write outranks a same-cycle byte start, leaving the new byte pending
      if (wr_tx && sel_i[0]) begin
        txdata_reg <= data_i[7:0];
        tx_empty_reg <= 1'b0;
      end
    end
  end

`ifdef SPI_SLV_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst) irq <= 1'b0;
    else      irq <= (rx_valid_reg & rx_ie_reg) | ((overrun_reg | underrun_reg | abort_reg) & err_ie_reg);
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bus-driven register checks plus an SPI master model at clk/16.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int HALF = 8;
  localparam logic [7:0] A_CTRL = 8'h30, A_TX = 8'h34, A_RX = 8'h38, A_ST = 8'h3C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_i = '0, addr_i = '0;
  logic [3:0]  sel_i = 4'hF;
  logic        we_i = 1'b0, req_valid_i = 1'b0;
  logic [31:0] data_o;
  logic        spi_sclk = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
`ifdef SPI_SLV_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic cpol_m = 1'b0, cpha_m = 1'b0;

  spi_slave dut (
    .clk(clk), .rst(rst), .data_i(data_i), .addr_i(addr_i), .sel_i(sel_i), .we_i(we_i),
    .req_valid_i(req_valid_i), .data_o(data_o), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
`ifdef SPI_SLV_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $fatal(1);
  end

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    addr_i = {24'h0, a}; data_i = d; sel_i = s; we_i = 1'b1; req_valid_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0; req_valid_i = 1'b0; sel_i = 4'hF;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    addr_i = {24'h0, a}; we_i = 1'b0; req_valid_i = 1'b1;
    @(negedge clk);
    d = data_o; req_valid_i = 1'b0;
  endtask

  task automatic frame_begin();
    spi_ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Optionally reads RXDATA so the bus read lands on the slave's byte-done clock
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit rd_at_done,
                          output logic [7:0] rx, output logic [31:0] rd_data);
    rx = '0; rd_data = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha_m) begin
        spi_mosi = tx[7-i];
        repeat (HALF) @(negedge clk);
        rx[7-i] = spi_miso;
        spi_sclk = ~cpol_m;
      end else begin
        spi_sclk = ~cpol_m;
        spi_mosi = tx[7-i];
        repeat (HALF) @(negedge clk);
        rx[7-i] = spi_miso;
        spi_sclk = cpol_m;
      end
      if (rd_at_done && i == 7) begin
        repeat (2) @(negedge clk);
        addr_i = {24'h0, A_RX}; we_i = 1'b0; req_valid_i = 1'b1;
        @(negedge clk);
        rd_data = data_o; req_valid_i = 1'b0;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (!cpha_m) spi_sclk = cpol_m;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (4) @(negedge clk);
    checks++;
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || data_o !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: oe=%b miso=%b data_o=%h required 0 0 0", spi_miso_oe, spi_miso, data_o);
    end
    rst = 1'b1;
    @(negedge clk);
    bus_read(A_ST, d); checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h required 00000002", d); end
    bus_read(A_CTRL, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h required 00000000", d); end
    bus_read(A_RX, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_rxdata: got %h required 00000000", d); end
    @(negedge clk); checks++;
    if (data_o !== 32'h0) begin errors++; $display("FAIL idle_data_o: got %h required 00000000", data_o); end
    $display("reset: status/ctrl/rxdata read back, %0d errors so far", errors);
  endtask

  task automatic test_ctrl_regs();
    logic [31:0] d, exp_all, exp_b1;
`ifdef SPI_SLV_IRQ_EN
    exp_all = 32'h0003FF07; exp_b1 = 32'h00030007;
`else
    exp_all = 32'h0000FF07; exp_b1 = 32'h00000007;
`endif
    bus_write(A_CTRL, 32'hFFFFFFFF, 4'hF);
    bus_read(A_CTRL, d); checks++;
    if (d !== exp_all) begin errors++; $display("FAIL ctrl_all_ones: got %h required %h", d, exp_all); end
    bus_write(A_CTRL, 32'h0, 4'b0010);
    bus_read(A_CTRL, d); checks++;
    if (d !== exp_b1) begin errors++; $display("FAIL ctrl_byte_enable: got %h required %h", d, exp_b1); end
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_write(A_TX, 32'h77, 4'hF);
    bus_read(A_ST, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL tx_pending_status: got %h required 00000000", d); end
    bus_read(A_TX, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL txdata_reads_zero: got %h required 00000000", d); end
    $display("ctrl: byte-enabled writes and readback done");
  endtask

  task automatic test_modes();
    logic [7:0] rx;
    logic [31:0] d, dn;
    for (int m = 0; m < 4; m++) begin
      cpol_m = m[0]; cpha_m = m[1];
      spi_sclk = cpol_m;
      bus_write(A_CTRL, {29'h0, cpha_m, cpol_m, 1'b1}, 4'hF);
      bus_write(A_TX, 32'hA5, 4'hF);
      frame_begin(); checks++;
      if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL mode%0d_oe_active: got %b required 1", m, spi_miso_oe); end
      spi_byte(8'h3C, 8, 1'b0, rx, dn);
      frame_end(); checks++;
      if (rx !== 8'hA5) begin errors++; $display("FAIL mode%0d_miso: got %h required a5", m, rx); end
      checks++;
      if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
        errors++; $display("FAIL mode%0d_idle_pins: oe=%b miso=%b required 0 0", m, spi_miso_oe, spi_miso);
      end
      bus_read(A_ST, d); checks++;
      if (d !== 32'h13) begin errors++; $display("FAIL mode%0d_status: got %h required 00000013", m, d); end
      bus_read(A_RX, d); checks++;
      if (d !== 32'h3C) begin errors++; $display("FAIL mode%0d_rxdata: got %h required 0000003c", m, d); end
      bus_write(A_ST, 32'h38, 4'hF);
      bus_read(A_ST, d); checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL mode%0d_status_cleared: got %h required 00000002", m, d); end
      $display("mode %0d: miso=%h rxdata=%h", m, rx, 8'h3C);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx1, rx2;
    logic [31:0] d, dn;
    cpol_m = 1'b0; cpha_m = 1'b0; spi_sclk = 1'b0;
    bus_write(A_CTRL, 32'h0000FF01, 4'hF);
    bus_write(A_TX, 32'h5A, 4'hF);
    frame_begin();
    spi_byte(8'h11, 8, 1'b0, rx1, dn);
    spi_byte(8'h22, 8, 1'b0, rx2, dn);
    frame_end(); checks++;
    if (rx1 !== 8'h5A) begin errors++; $display("FAIL burst_miso1: got %h required 5a", rx1); end
    checks++;
    if (rx2 !== 8'hFF) begin errors++; $display("FAIL burst_miso2_dummy: got %h required ff", rx2); end
    bus_read(A_ST, d); checks++;
    if (d !== 32'h1B) begin errors++; $display("FAIL burst_status: got %h required 0000001b", d); end
    bus_write(A_ST, 32'h18, 4'hF);
    bus_read(A_ST, d); checks++;
    if (d !== 32'h03) begin errors++; $display("FAIL burst_w1c: got %h required 00000003", d); end
    bus_read(A_RX, d); checks++;
    if (d !== 32'h11) begin errors++; $display("FAIL burst_rx_kept_first: got %h required 00000011", d); end
    $display("burst: miso %h %h", rx1, rx2);
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic [31:0] d, dn;
    bus_write(A_CTRL, 32'h1, 4'hF);
    bus_write(A_TX, 32'h66, 4'hF);
    frame_begin();
    spi_byte(8'hF0, 5, 1'b0, rx, dn);
    frame_end(); checks++;
    if (spi_miso !== 1'b0) begin errors++; $display("FAIL abort_miso_low: got %b required 0", spi_miso); end
    bus_read(A_ST, d); checks++;
    if (d !== 32'h22) begin errors++; $display("FAIL abort_status: got %h required 00000022", d); end
    bus_write(A_ST, 32'h20, 4'hF);
    bus_write(A_TX, 32'h00, 4'hF);
    frame_begin();
    spi_byte(8'h81, 8, 1'b0, rx, dn);
    frame_end();
    bus_read(A_ST, d); checks++;
    if (d !== 32'h13) begin errors++; $display("FAIL abort_next_status: got %h required 00000013", d); end
    bus_read(A_RX, d); checks++;
    if (d !== 32'h81) begin errors++; $display("FAIL abort_next_rxdata: got %h required 00000081", d); end
    bus_write(A_ST, 32'h38, 4'hF);
    $display("abort: partial frame flagged, next frame rx=81");
  endtask

  task automatic test_read_collision();
    logic [7:0] rx;
    logic [31:0] d, rd;
    bus_write(A_TX, 32'h12, 4'hF);
    frame_begin();
    spi_byte(8'h3C, 8, 1'b0, rx, rd);
    frame_end();
    bus_write(A_ST, 32'h38, 4'hF);
    bus_write(A_TX, 32'h34, 4'hF);
    frame_begin();
    spi_byte(8'hC3, 8, 1'b1, rx, rd);
    frame_end(); checks++;
    if (rd !== 32'h3C) begin errors++; $display("FAIL collide_read_old: got %h required 0000003c", rd); end
    checks++;
    if (rx !== 8'h34) begin errors++; $display("FAIL collide_miso: got %h required 34", rx); end
    bus_read(A_ST, d); checks++;
    if (d !== 32'h13) begin errors++; $display("FAIL collide_status: got %h required 00000013", d); end
    bus_read(A_RX, d); checks++;
    if (d !== 32'hC3) begin errors++; $display("FAIL collide_rx_new: got %h required 000000c3", d); end
    bus_write(A_ST, 32'h38, 4'hF);
    $display("collision: read returned %h, new byte %h held", rd[7:0], 8'hC3);
  endtask

`ifdef SPI_SLV_IRQ_EN
  task automatic test_irq();
    logic [7:0] rx;
    logic [31:0] d, dn;
    bus_write(A_CTRL, 32'h00010001, 4'hF);
    bus_write(A_TX, 32'h55, 4'hF);
    frame_begin();
    spi_byte(8'h99, 8, 1'b0, rx, dn);
    frame_end(); checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b required 1", irq); end
    bus_read(A_RX, d);
    @(negedge clk); checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b required 0", irq); end
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_write(A_ST, 32'h38, 4'hF);
    $display("irq: set on rx, cleared after read of %h", d[7:0]);
  endtask
`endif

  initial begin
    test_reset();
    test_ctrl_regs();
    test_modes();
    test_back_to_back();
    test_abort();
    test_read_collision();
`ifdef SPI_SLV_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
